// File: rtl/weight_loader_pkg.sv
// Shared widths and FSM encodings for the sparse-kernel weight loader.
package weight_loader_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int KERNEL_SIZE  = 9;
  localparam int KERNEL_WIDTH = DATA_WIDTH * KERNEL_SIZE;
  localparam int POS_WIDTH    = 4;

  typedef enum logic [1:0] {
    S_FLAG = 2'd0,
    S_DATA = 2'd1,
    S_FULL = 2'd2
  } state_e;

endpackage

// File: rtl/wei_pos_encoder.sv
// Priority encoder: lowest kernel position k whose mask bit (8-k) is set,
// plus a flag telling whether that is the only remaining position.
import weight_loader_pkg::*;

module wei_pos_encoder (
  input  logic [KERNEL_SIZE-1:0] mask_i,
  output logic [POS_WIDTH-1:0]   pos_o,
  output logic                   last_o
);

  // Scanning from the highest position down lets the lowest one win.
  always_comb begin
    pos_o = '0;
    for (int i = KERNEL_SIZE - 1; i >= 0; i--) begin
      if (mask_i[KERNEL_SIZE-1-i]) pos_o = POS_WIDTH'(i);
    end
  end

  assign last_o = (mask_i != '0) && ((mask_i & (mask_i - 1'b1)) == '0);

endmodule

// File: rtl/weight_loader.sv
// Sparse 3x3 kernel decompressor with a shadow/active double buffer.
//
// state  | meaning
// S_FLAG | waiting for the flag word of the next kernel
// S_DATA | accepting non-zero weight bytes into the shadow buffer
// S_FULL | shadow buffer complete, waiting for a load request
import weight_loader_pkg::*;

module weight_loader (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flag_valid,
  output logic                    flag_ready,
  input  logic [KERNEL_SIZE-1:0]  flag_data,
  input  logic                    wei_valid,
  output logic                    wei_ready,
  input  logic [DATA_WIDTH-1:0]   wei_data,
  input  logic                    load_req,
  output logic                    wr_req_wei_flag,
  output logic [KERNEL_SIZE-1:0]  wr_data_wei_flag,
  output logic [KERNEL_WIDTH-1:0] wei_array_full,
  output logic                    shadow_full
);

  state_e                  state_q, state_d;
  logic                    pend_q, pend_d;
  logic [KERNEL_SIZE-1:0]  mask_q, mask_d;
  logic [KERNEL_SIZE-1:0]  shadow_flag_q, shadow_flag_d;
  logic [KERNEL_WIDTH-1:0] shadow_wei_q, shadow_wei_d;
  logic [KERNEL_SIZE-1:0]  act_flag_q, act_flag_d;
  logic [KERNEL_WIDTH-1:0] act_wei_q, act_wei_d;
  logic                    wr_req_q, wr_req_d;

  logic [POS_WIDTH-1:0]    pos;
  logic                    last;

  wei_pos_encoder u_pos_enc (
    .mask_i (mask_q),
    .pos_o  (pos),
    .last_o (last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_FLAG;
      pend_q        <= 1'b0;
      mask_q        <= '0;
      shadow_flag_q <= '0;
      shadow_wei_q  <= '0;
      act_flag_q    <= '0;
      act_wei_q     <= '0;
      wr_req_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      mask_q        <= mask_d;
      shadow_flag_q <= shadow_flag_d;
      shadow_wei_q  <= shadow_wei_d;
      act_flag_q    <= act_flag_d;
      act_wei_q     <= act_wei_d;
      wr_req_q      <= wr_req_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q | load_req;
    mask_d        = mask_q;
    shadow_flag_d = shadow_flag_q;
    shadow_wei_d  = shadow_wei_q;
    act_flag_d    = act_flag_q;
    act_wei_d     = act_wei_q;
    wr_req_d      = 1'b0;

    case (state_q)
      S_FLAG: begin
        if (flag_valid) begin
          shadow_flag_d = flag_data;
          mask_d        = flag_data;
          shadow_wei_d  = '0;
          state_d       = (flag_data != '0) ? S_DATA : S_FULL;
        end
      end
      S_DATA: begin
        if (wei_valid) begin
          for (int i = 0; i < KERNEL_SIZE; i++) begin
            if (pos == POS_WIDTH'(i)) begin
              shadow_wei_d[i*DATA_WIDTH +: DATA_WIDTH] = wei_data;
              mask_d[KERNEL_SIZE-1-i]                  = 1'b0;
            end
          end
          if (last) state_d = S_FULL;
        end
      end
      S_FULL: begin
        // A request arriving on the transfer edge belongs to the next kernel.
        if (pend_q) begin
          act_flag_d = shadow_flag_q;
          act_wei_d  = shadow_wei_q;
          wr_req_d   = 1'b1;
          pend_d     = load_req;
          state_d    = S_FLAG;
        end
      end
      default: state_d = S_FLAG;
    endcase
  end

  assign flag_ready       = (state_q == S_FLAG);
  assign wei_ready        = (state_q == S_DATA);
  assign shadow_full      = (state_q == S_FULL);
  assign wr_req_wei_flag  = wr_req_q;
  assign wr_data_wei_flag = act_flag_q;
  assign wei_array_full   = act_wei_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: hand-computed kernels, strobe timing and buffering.
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        flag_valid;
  logic        flag_ready;
  logic [8:0]  flag_data;
  logic        wei_valid;
  logic        wei_ready;
  logic [7:0]  wei_data;
  logic        load_req;
  logic        wr_req_wei_flag;
  logic [8:0]  wr_data_wei_flag;
  logic [71:0] wei_array_full;
  logic        shadow_full;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int strobes  = 0;
  bit wei_seen = 1'b0;
  int hs_cyc;
  int st_cyc;
  int base;

  weight_loader dut (
    .clk              (clk),
    .reset            (reset),
    .flag_valid       (flag_valid),
    .flag_ready       (flag_ready),
    .flag_data        (flag_data),
    .wei_valid        (wei_valid),
    .wei_ready        (wei_ready),
    .wei_data         (wei_data),
    .load_req         (load_req),
    .wr_req_wei_flag  (wr_req_wei_flag),
    .wr_data_wei_flag (wr_data_wei_flag),
    .wei_array_full   (wei_array_full),
    .shadow_full      (shadow_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (wr_req_wei_flag) strobes++;
    if (wei_ready) wei_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present a flag; hs_cyc is the cycle index (posedge count) of the handshake.
  task automatic send_flag(input logic [8:0] f, input logic lr);
    int n = 0;
    flag_valid = 1'b1;
    flag_data  = f;
    load_req   = lr;
    while (!flag_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("flag_timeout", 72'd0, 72'd1);
    hs_cyc = cyc;
    @(negedge clk);
    flag_valid = 1'b0;
    load_req   = 1'b0;
  endtask

  // Beat i is bits [8i+7:8i] of w; optional one-cycle stall before beat stall_at.
  task automatic send_weights(input logic [71:0] w, input int n, input int stall_at);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      if (i == stall_at) begin
        wei_valid = 1'b0;
        @(negedge clk);
      end
      wei_valid = 1'b1;
      wei_data  = w[i*8 +: 8];
      while (!wei_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) begin
        chk("wei_timeout", 72'd0, 72'd1);
        wei_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    wei_valid = 1'b0;
  endtask

  task automatic wait_strobe(input int bound);
    int t = 0;
    while (!wr_req_wei_flag && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (!wr_req_wei_flag) chk("strobe_timeout", 72'd0, 72'd1);
    st_cyc = cyc;
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset      = 1'b0;
    flag_valid = 1'b0;
    flag_data  = '0;
    wei_valid  = 1'b0;
    wei_data   = '0;
    load_req   = 1'b0;

    // reset held 3 cycles
    idle(3);
    chk("rst_flag_ready", 72'(flag_ready), 72'd1);
    reset = 1'b1;
    idle(2);
    chk("rst_wei_ready", 72'(wei_ready), 72'd0);
    chk("rst_shadow_full", 72'(shadow_full), 72'd0);
    chk("rst_strobes", 72'(strobes), 72'd0);
    chk("rst_flag_out", 72'(wr_data_wei_flag), 72'd0);
    chk("rst_array", wei_array_full, 72'd0);

    // sparse kernel, load_req with the flag: strobe in cycle 6
    send_flag(9'b101000011, 1'b1);
    send_weights(72'h44332211, 4, 99);
    wait_strobe(20);
    chk("a_strobe_cycle", 72'(st_cyc - hs_cyc), 72'd6);
    chk("a_array", wei_array_full, 72'h443300000000220011);
    chk("a_flag", 72'(wr_data_wei_flag), 72'h143);
    chk("a_flag_ready", 72'(flag_ready), 72'd1);
    idle(1);
    chk("a_strobe_width", 72'(wr_req_wei_flag), 72'd0);

    // all-zero kernel: no weight beats, strobe 2 cycles after flag
    idle(2);
    wei_seen = 1'b0;
    send_flag(9'h000, 1'b1);
    wait_strobe(20);
    chk("z_strobe_cycle", 72'(st_cyc - hs_cyc), 72'd2);
    chk("z_array", wei_array_full, 72'd0);
    chk("z_flag", 72'(wr_data_wei_flag), 72'd0);
    chk("z_wei_ready_seen", 72'(wei_seen), 72'd0);

    // dense kernel with a stall; request withheld
    idle(2);
    send_flag(9'h1FF, 1'b0);
    send_weights(72'hA8A7A6A5A4A3A2A1A0, 9, 3);
    base = strobes;
    idle(10);
    chk("d_shadow_full", 72'(shadow_full), 72'd1);
    chk("d_flag_ready", 72'(flag_ready), 72'd0);
    chk("d_array_held", wei_array_full, 72'd0);
    chk("d_no_strobe", 72'(strobes - base), 72'd0);
    pulse_req();
    chk("d_array_pre", wei_array_full, 72'd0);
    chk("d_strobe_pre", 72'(wr_req_wei_flag), 72'd0);
    idle(1);
    chk("d_strobe", 72'(wr_req_wei_flag), 72'd1);
    chk("d_array", wei_array_full, 72'hA8A7A6A5A4A3A2A1A0);
    chk("d_flag", 72'(wr_data_wei_flag), 72'h1FF);

    // two requests before full give one strobe; next kernel needs a fresh request
    idle(2);
    base = strobes;
    send_flag(9'h003, 1'b1);
    pulse_req();
    send_weights(72'hA55A, 2, 99);
    wait_strobe(20);
    idle(5);
    chk("p_one_strobe", 72'(strobes - base), 72'd1);
    chk("p_array", wei_array_full, 72'hA55A00000000000000);
    send_flag(9'h100, 1'b0);
    send_weights(72'h77, 1, 99);
    idle(5);
    chk("p2_shadow_full", 72'(shadow_full), 72'd1);
    chk("p2_no_swap", wei_array_full, 72'hA55A00000000000000);
    chk("p2_strobes", 72'(strobes - base), 72'd1);
    pulse_req();
    wait_strobe(10);
    chk("p2_array", wei_array_full, 72'h77);
    chk("p2_flag", 72'(wr_data_wei_flag), 72'h100);

    // reset mid-kernel discards the partial shadow
    idle(2);
    send_flag(9'h0F0, 1'b0);
    send_weights(72'hDDEE, 2, 99);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(1);
    chk("r_flag_ready", 72'(flag_ready), 72'd1);
    chk("r_wei_ready", 72'(wei_ready), 72'd0);
    chk("r_array", wei_array_full, 72'd0);
    send_flag(9'h081, 1'b1);
    send_weights(72'h3412, 2, 99);
    wait_strobe(20);
    chk("r_strobe_cycle", 72'(st_cyc - hs_cyc), 72'd4);
    chk("r_array_clean", wei_array_full, 72'h340000000000001200);
    chk("r_flag", 72'(wr_data_wei_flag), 72'h081);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
